// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and width helpers for the pipeline hazard unit.
// Slot fields use fixed maximum widths so the same slot_t serves every parameter set.
package hazard_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_NFILE = 2;
    localparam int DEF_NSRC  = 3;
    localparam int DEF_DEPTH = 4;

    // Upper bounds for slot fields; the top zero-extends into these.
    localparam int FILE_WMAX = 4;
    localparam int IDX_WMAX  = 10;
    localparam int REM_WMAX  = 8;

    typedef enum logic [FILE_WMAX-1:0] {
        RF_INT = 4'd0,
        RF_FLT = 4'd1
    } reg_file_e;

    typedef struct packed {
        logic                valid;
        logic [FILE_WMAX-1:0] file;
        logic [IDX_WMAX-1:0]  idx;
        logic [REM_WMAX-1:0]  rem;
    } slot_t;

    // ceil(log2(n)) with a floor of one bit so single-entry dimensions stay legal
    function automatic int hz_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_zero_reg(input logic [FILE_WMAX-1:0] f,
                                         input logic [IDX_WMAX-1:0]  i);
        return (f == RF_INT) && (i == '0);
    endfunction

    function automatic logic [REM_WMAX-1:0] rem_dec(input logic [REM_WMAX-1:0] r);
        return (r == '0) ? '0 : r - 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Issue/forwarding bundle between the core pipeline and the hazard unit.
// master = core side (drives issue and slot results), slave = hazard unit.
interface pipe_hazard_unit_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NFILE = 2,
    parameter int NSRC  = 3,
    parameter int DEPTH = 4
);
    localparam int RW = hazard_pkg::hz_clog2(NREG);
    localparam int FW = hazard_pkg::hz_clog2(NFILE);
    localparam int LW = hazard_pkg::hz_clog2(DEPTH + 1);

    logic                  adv;
    logic                  flush;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [NSRC-1:0]       iss_src_used;
    logic [NSRC*FW-1:0]    iss_src_file;
    logic [NSRC*RW-1:0]    iss_src_idx;
    logic                  iss_rd_we;
    logic [FW-1:0]         iss_rd_file;
    logic [RW-1:0]         iss_rd_idx;
    logic [LW-1:0]         iss_lat;
    logic [DEPTH*XLEN-1:0] slot_data;
    logic [NSRC-1:0]       fwd_hit;
    logic [NSRC*XLEN-1:0]  fwd_val;

    modport master (
        output adv, flush, iss_valid, iss_src_used, iss_src_file, iss_src_idx,
               iss_rd_we, iss_rd_file, iss_rd_idx, iss_lat, slot_data,
        input  iss_ready, fwd_hit, fwd_val
    );

    modport slave (
        input  adv, flush, iss_valid, iss_src_used, iss_src_file, iss_src_idx,
               iss_rd_we, iss_rd_file, iss_rd_idx, iss_lat, slot_data,
        output iss_ready, fwd_hit, fwd_val
    );

endinterface

// File: rtl/pipe_hazard_unit_src_match.sv
// Per-operand search of the shadow pipeline: the youngest matching slot decides
// between forward (rem==0) and hazard (rem>0); integer x0 never matches.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SEL_W = 2
) (
    input  logic                 used,
    input  logic [FILE_WMAX-1:0] file,
    input  logic [IDX_WMAX-1:0]  idx,
    input  slot_t                slots [DEPTH],
    output logic                 hit,
    output logic                 hazard,
    output logic [SEL_W-1:0]     sel
);

    logic [DEPTH-1:0]    match;
    logic                found;
    logic [REM_WMAX-1:0] found_rem;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi] = used && slots[gi].valid &&
                           (slots[gi].file == file) && (slots[gi].idx == idx) &&
                           !is_zero_reg(file, idx);
    end

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        found_rem = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                found     = 1'b1;
                sel       = SEL_W'(k);
                found_rem = slots[k].rem;
            end
        end
    end

    assign hit    = found && (found_rem == '0);
    assign hazard = found && (found_rem != '0);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall/forward control: DEPTH-slot shadow pipeline of in-flight register writers.
// Optional HAZARD_PERF_EN adds free-running stall and flush event counters.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int NFILE       = 2,
    parameter int NSRC        = 3,
    parameter int DEPTH       = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    localparam int RW    = hz_clog2(NREG);
    localparam int FW    = hz_clog2(NFILE);
    localparam int SEL_W = hz_clog2(DEPTH);

    slot_t slot_reg  [DEPTH];
    slot_t slot_next [DEPTH];

    logic [NSRC-1:0]      src_hit;
    logic [NSRC-1:0]      src_hazard;
    logic [SEL_W-1:0]     src_sel [NSRC];
    logic [NSRC-1:0]      fwd_hit_vec;
    logic [NSRC*XLEN-1:0] fwd_val_vec;
    logic                 any_hazard;
    logic                 issue_take;
    slot_t                new_slot;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        hazard_src_match #(
            .DEPTH (DEPTH),
            .SEL_W (SEL_W)
        ) u_match (
            .used   (hz.iss_src_used[gi]),
            .file   (FILE_WMAX'(hz.iss_src_file[gi*FW +: FW])),
            .idx    (IDX_WMAX'(hz.iss_src_idx[gi*RW +: RW])),
            .slots  (slot_reg),
            .hit    (src_hit[gi]),
            .hazard (src_hazard[gi]),
            .sel    (src_sel[gi])
        );

        assign fwd_hit_vec[gi] = hz.iss_valid && src_hit[gi];
        assign fwd_val_vec[gi*XLEN +: XLEN] =
            fwd_hit_vec[gi] ? hz.slot_data[src_sel[gi]*XLEN +: XLEN] : '0;
    end

    assign any_hazard   = hz.iss_valid && (|src_hazard);
    assign hz.iss_ready = !any_hazard;
    assign hz.fwd_hit   = fwd_hit_vec;
    assign hz.fwd_val   = fwd_val_vec;

    // A redirect drops the instruction being issued; writes to x0 are never tracked.
    assign issue_take = hz.iss_valid && hz.iss_ready && hz.iss_rd_we && !hz.flush &&
                        !is_zero_reg(FILE_WMAX'(hz.iss_rd_file), IDX_WMAX'(hz.iss_rd_idx));

    always_comb begin
        new_slot       = '0;
        new_slot.valid = 1'b1;
        new_slot.file  = FILE_WMAX'(hz.iss_rd_file);
        new_slot.idx   = IDX_WMAX'(hz.iss_rd_idx);
        new_slot.rem   = REM_WMAX'(hz.iss_lat);
    end

    // Flush kills the FLUSH_DEPTH youngest instructions: with adv they are discarded
    // as they move up, so only older writers survive the shift; without adv they die in place.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_next[k] = slot_reg[k];
        end
        if (hz.adv) begin
            for (int k = 1; k < DEPTH; k++) begin
                if (hz.flush && ((k - 1) < FLUSH_DEPTH)) begin
                    slot_next[k] = '0;
                end else begin
                    slot_next[k]     = slot_reg[k-1];
                    slot_next[k].rem = rem_dec(slot_reg[k-1].rem);
                end
            end
            slot_next[0] = issue_take ? new_slot : '0;
        end else if (hz.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_DEPTH) begin
                    slot_next[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= slot_next[k];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (hz.iss_valid && !hz.iss_ready) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (hz.flush) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_stall = perf_stall_reg;
    assign perf_flush = perf_flush_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Table-driven bench for pipe_hazard_unit with a scoreboard of expected issue responses.
// Hand sequences cover the no-advance hold and the asynchronous reset.
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_unit_if hz_bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    pipe_hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .hz         (hz_bus)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall (perf_stall),
        .perf_flush (perf_flush)
`endif
    );

    typedef struct {
        logic         adv;
        logic         flush;
        logic         iv;
        logic [2:0]   used;
        logic [2:0]   sfile;
        logic [14:0]  sidx;
        logic         we;
        logic         rfile;
        logic [4:0]   ridx;
        logic [2:0]   lat;
        logic [127:0] sd;
        logic         er;
        logic [2:0]   eh;
        logic [95:0]  ev;
    } vec_t;

    typedef struct {
        int          id;
        logic        er;
        logic [2:0]  eh;
        logic [95:0] ev;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   vec_id    = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic logic [127:0] sd(input logic [31:0] d0, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t wr(input logic adv, input logic flush, input logic rfile,
                                input logic [4:0] ridx, input logic [2:0] lat);
        vec_t v;
        v       = '{default: '0};
        v.adv   = adv;
        v.flush = flush;
        v.iv    = 1'b1;
        v.we    = 1'b1;
        v.rfile = rfile;
        v.ridx  = ridx;
        v.lat   = lat;
        v.sd    = sd(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        v.er    = 1'b1;
        return v;
    endfunction

    function automatic vec_t rd(input logic adv, input logic [2:0] used, input logic [2:0] sfile,
                                input logic [4:0] i0, input logic [4:0] i1, input logic [127:0] sdv,
                                input logic er, input logic [2:0] eh,
                                input logic [31:0] v0, input logic [31:0] v1);
        vec_t v;
        v       = '{default: '0};
        v.adv   = adv;
        v.iv    = 1'b1;
        v.used  = used;
        v.sfile = sfile;
        v.sidx  = {5'd0, i1, i0};
        v.sd    = sdv;
        v.er    = er;
        v.eh    = eh;
        v.ev    = {32'd0, v1, v0};
        return v;
    endfunction

    function automatic vec_t idle(input logic adv, input logic flush);
        vec_t v;
        v       = '{default: '0};
        v.adv   = adv;
        v.flush = flush;
        v.er    = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hz_bus.adv          = v.adv;
        hz_bus.flush        = v.flush;
        hz_bus.iss_valid    = v.iv;
        hz_bus.iss_src_used = v.used;
        hz_bus.iss_src_file = v.sfile;
        hz_bus.iss_src_idx  = v.sidx;
        hz_bus.iss_rd_we    = v.we;
        hz_bus.iss_rd_file  = v.rfile;
        hz_bus.iss_rd_idx   = v.ridx;
        hz_bus.iss_lat      = v.lat;
        hz_bus.slot_data    = v.sd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.id = vec_id;
        e.er = v.er;
        e.eh = v.eh;
        e.ev = v.ev;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got empty queue, required one pending entry");
            return;
        end
        e = sb.pop_front();
        $display("[TB] vec %0d ready=%0b hit=%03b val0=%08h", e.id, hz_bus.iss_ready,
                 hz_bus.fwd_hit, hz_bus.fwd_val[31:0]);
        if (hz_bus.iss_ready !== e.er) begin
            n_fail++;
            $display("FAIL vec%0d iss_ready: got %0b required %0b", e.id, hz_bus.iss_ready, e.er);
        end
        n_tests++;
        if (hz_bus.fwd_hit !== e.eh) begin
            n_fail++;
            $display("FAIL vec%0d fwd_hit: got %03b required %03b", e.id, hz_bus.fwd_hit, e.eh);
        end
        for (int s = 0; s < 3; s++) begin
            if (e.eh[s]) begin
                n_tests++;
                if (hz_bus.fwd_val[s*32 +: 32] !== e.ev[s*32 +: 32]) begin
                    n_fail++;
                    $display("FAIL vec%0d fwd_val[%0d]: got %08h required %08h", e.id, s,
                             hz_bus.fwd_val[s*32 +: 32], e.ev[s*32 +: 32]);
                end
            end
        end
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (perf_stall !== 32'(exp_stall)) begin
            n_fail++;
            $display("FAIL vec%0d perf_stall: got %0d required %0d", e.id, perf_stall, exp_stall);
        end
        n_tests++;
        if (perf_flush !== 32'(exp_flush)) begin
            n_fail++;
            $display("FAIL vec%0d perf_flush: got %0d required %0d", e.id, perf_flush, exp_flush);
        end
`endif
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        push_exp(v);
        @(negedge clk);
        check_front();
        if (v.iv && !v.er) exp_stall++;
        if (v.flush) exp_flush++;
        vec_id++;
    endtask

    initial begin
        rst = 1'b1;
        drive(idle(1'b0, 1'b0));

        // Reset state: empty pipeline, a reader sees no hazard and no forward.
        apply(rd(1, 3'b001, 3'b000, 5'd5, 5'd0, sd(1, 2, 3, 4), 1, 3'b000, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;

        tbl.push_back(idle(1, 0));
        // back-to-back ALU dependency
        tbl.push_back(wr(1, 0, 1'b0, 5'd5, 3'd0));
        tbl.push_back(rd(1, 3'b001, 3'b000, 5'd5, 5'd0, sd(32'hAA, 1, 2, 3), 1, 3'b001, 32'hAA, 0));
        // load-use: one stall, then forward from slot 1
        tbl.push_back(wr(1, 0, 1'b0, 5'd7, 3'd1));
        tbl.push_back(rd(1, 3'b001, 3'b000, 5'd7, 5'd0, sd(9, 9, 9, 9), 0, 3'b000, 0, 0));
        tbl.push_back(rd(1, 3'b001, 3'b000, 5'd7, 5'd0, sd(1, 32'h77, 2, 3), 1, 3'b001, 32'h77, 0));
        // zero register and file separation
        tbl.push_back(wr(1, 0, 1'b0, 5'd0, 3'd2));
        tbl.push_back(wr(1, 0, 1'b1, 5'd3, 3'd2));
        tbl.push_back(rd(1, 3'b011, 3'b000, 5'd0, 5'd3, sd(1, 2, 3, 4), 1, 3'b000, 0, 0));
        tbl.push_back(rd(0, 3'b001, 3'b001, 5'd3, 5'd0, sd(1, 2, 3, 4), 0, 3'b000, 0, 0));
        // youngest wins
        tbl.push_back(wr(1, 0, 1'b0, 5'd9, 3'd0));
        tbl.push_back(wr(1, 0, 1'b0, 5'd9, 3'd0));
        tbl.push_back(rd(0, 3'b001, 3'b000, 5'd9, 5'd0, sd(32'h22, 32'h11, 0, 0), 1, 3'b001, 32'h22, 0));
        // younger rem==0 shadows an older rem>0 of the same register
        tbl.push_back(wr(1, 0, 1'b0, 5'd12, 3'd3));
        tbl.push_back(wr(1, 0, 1'b0, 5'd12, 3'd0));
        tbl.push_back(rd(0, 3'b011, 3'b000, 5'd12, 5'd9, sd(32'h33, 5, 32'h99, 6), 1, 3'b011,
                         32'h33, 32'h99));
        // flush with adv: only the oldest x4 writer survives into slot 3
        tbl.push_back(wr(1, 0, 1'b0, 5'd4, 3'd3));
        tbl.push_back(wr(1, 0, 1'b0, 5'd4, 3'd3));
        tbl.push_back(wr(1, 0, 1'b0, 5'd4, 3'd3));
        tbl.push_back(wr(1, 1, 1'b0, 5'd4, 3'd0));
        tbl.push_back(rd(0, 3'b001, 3'b000, 5'd4, 5'd0, sd(32'hBAD, 32'hBAD, 32'hBAD, 32'h44), 1,
                         3'b001, 32'h44, 0));
        // flush without adv kills in place
        tbl.push_back(wr(1, 0, 1'b0, 5'd6, 3'd3));
        tbl.push_back(idle(0, 1));
        tbl.push_back(rd(0, 3'b001, 3'b000, 5'd6, 5'd0, sd(1, 2, 3, 4), 1, 3'b000, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // No advance: a lat=2 writer keeps stalling its reader indefinitely.
        apply(wr(1, 0, 1'b0, 5'd8, 3'd2));
        for (int c = 0; c < 5; c++) begin
            apply(rd(0, 3'b001, 3'b000, 5'd8, 5'd0, sd(1, 2, 3, 4), 0, 3'b000, 0, 0));
        end

        // Asynchronous reset between edges empties the pipeline at once.
        #2 rst = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        push_exp(rd(0, 3'b001, 3'b000, 5'd8, 5'd0, sd(1, 2, 3, 4), 1, 3'b000, 0, 0));
        vec_id++;
        check_front();
        @(posedge clk);
        #1 rst = 1'b0;
        apply(rd(1, 3'b001, 3'b000, 5'd8, 5'd0, sd(1, 2, 3, 4), 1, 3'b000, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised successor to the core's hand-coded stall/forwarding control.
- Tracks in-flight register writers in a DEPTH-slot shadow pipeline that advances with the core's stages.
- For each source of the instruction being issued, decides one of three outcomes: stall, forward from a slot, or read the register file.
- Handles multiple register files, any number of source operands, per-instruction result latency, and partial flush on branch redirect.

Parameters:
XLEN, 32, data width
NREG, 32, registers per file (index width RW = clog2(NREG))
NFILE, 2, register files (0 = integer with hardwired zero at index 0, 1 = float)
NSRC, 3, source operands per instruction
DEPTH, 4, tracked slots from issue to writeback inclusive
FLUSH_DEPTH, 2, youngest slots killed by flush (1..DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
adv  in  1  core advances all stages this cycle
flush  in  1  redirect; kill slots 0..FLUSH_DEPTH-1
iss_valid  in  1  decoded instruction present
iss_ready  out  1  no unresolved hazard; instruction may enter exec
iss_src_used  in  NSRC  per-source use mask
iss_src_file  in  NSRC*clog2(NFILE)  file of each source
iss_src_idx  in  NSRC*RW  register index of each source
iss_rd_we  in  1  instruction writes a register
iss_rd_file  in  clog2(NFILE)  destination file
iss_rd_idx  in  RW  destination index
iss_lat  in  clog2(DEPTH+1)  advances until result is forwardable (0..DEPTH-1)
slot_data  in  DEPTH*XLEN  result bus of each stage, slot k = k advances after issue
fwd_hit  out  NSRC  source is taken from a slot
fwd_val  out  NSRC*XLEN  forwarded value (valid only when fwd_hit)

Behaviour:
- Slot state: valid, file, idx, rem (remaining latency). Reset clears all valid bits and all rem fields; iss_ready resets to 1 (combinational from empty state). fwd_hit resets to 0.
- Match rule:
  - Source s matches slot k when: used[s], slot valid, file equal, idx equal.
  - A file-0 index-0 source never matches.
  - The youngest (lowest k) matching slot wins.
- Per source:
  - No match: fwd_hit=0 (read the register file).
  - Match with rem==0: fwd_hit=1, fwd_val = slot_data[k].
  - Match with rem>0: hazard.
- iss_ready = !(any hazard). The hazard check is combinational, with zero-cycle latency from issue inputs.
- On adv (posedge):
  - Slot k+1 ← slot k, with rem decremented and saturating at 0.
  - Slot DEPTH-1 retires. The register file must write-before-read the same cycle; the core guarantees this.
  - Slot 0 ← issued instruction if iss_valid && iss_ready && iss_rd_we, with rem = iss_lat.
  - A write to file-0 index 0 is not tracked.
  - Otherwise slot 0 ← bubble (valid=0).
- No adv: state holds; rem does not decrement. Latency is counted in stage advances, not cycles.
- flush (posedge):
  - Slots 0..FLUSH_DEPTH-1 become invalid after the shift, if adv is also high.
  - The issue in that cycle is dropped.
  - Older slots shift normally.
- flush with adv=0: kill in place; no shift.
- iss_valid=0: iss_ready=1, fwd_hit=0; a bubble enters on adv.
- Same register in two slots: only the youngest is considered. An older slot with rem>0 never stalls if a younger one matches.
- rst mid-operation: all slots invalid immediately (async); the next cycle behaves as empty.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, two extra outputs are added: perf_stall (32) and perf_flush (32).
  - perf_stall counts posedges with iss_valid && !iss_ready.
  - perf_flush counts posedges with flush.
  - Both wrap at 2^32 and are cleared by rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - slot_t struct: valid, file, idx, rem.
  - reg_file_e enum: RF_INT = 0, RF_FLT = 1.
  - Width helper constants derived from the parameters.
- Sub-module hazard_src_match: one instance per source (generate loop). It does the youngest-match priority search over slots and outputs hit, hazard and selected slot index.
- The top level holds the slot shift register, flush kill, perf counters and the operand mux.

Test Plan:
- Back-to-back ALU dependency:
  - Stimulus: x5 written with lat=0, next instruction reads x5, slot_data[0]=0x0000_00AA.
  - Required: iss_ready=1, fwd_hit[0]=1, fwd_val[0]=0xAA.
- Load-use:
  - Stimulus: x7 written with lat=1, next instruction reads x7.
  - Required: iss_ready=0 for exactly one adv; then fwd_hit=1 from slot 1 with value slot_data[1].
- Zero register and file separation:
  - Stimulus: writer x0 lat=2, then writer f3 lat=2; reader uses x0 and x3.
  - Required: iss_ready=1, fwd_hit=0 on both sources.
- Youngest wins:
  - Stimulus: x9 written lat=0 into slot 1 (slot_data[1]=0x11), then x9 written lat=0 into slot 0 (slot_data[0]=0x22).
  - Required: reader gets fwd_val=0x22.
- Flush with FLUSH_DEPTH=2:
  - Stimulus: slots 0..2 all hold x4 lat=3; assert flush with adv.
  - Required: only former slot 2 survives, now in slot 3 with rem=0. A reader of x4 then gets iss_ready=1, fwd_hit=1 from slot 3.
- No-advance hold and async reset:
  - Stimulus: hold adv=0 for 5 cycles with a pending lat=2 writer.
  - Required: iss_ready stays 0 throughout. Pulsing rst mid-cycle gives iss_ready=1 immediately; with HAZARD_PERF_EN, perf_stall=0.
